grayscale_stream: RTL and testbench

//  Parametrised, back-pressured pixel engine for the grayscale AFU, between requestor read data and write path.

---
 rtl/grayscale_stream.sv | 156 +++++++++++++++
 tb/tb_grayscale_stream.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grayscale_stream.sv
// Streaming RGBA line engine: pass / luma / average / invert per beat, fixed-latency
// compute pipeline feeding a credit-guarded first-word-fall-through output FIFO.
module grayscale_stream #(
    parameter int LINE_WIDTH  = 512,
    parameter int PIPE_STAGES = 3,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            mode,
    input  logic [LINE_WIDTH-1:0] data_in,
    input  logic                  last_in,
    input  logic                  valid_in,
    output logic                  ready_in,
    output logic [LINE_WIDTH-1:0] data_out,
    output logic                  last_out,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic [31:0]           lines_in,
    output logic [31:0]           lines_out,
    output logic                  idle,
    output logic                  done
);
    localparam int NPIX   = LINE_WIDTH / 32;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LAST_S = PIPE_STAGES - 1;
    localparam logic [PTR_W:0] DEPTH = FIFO_DEPTH[PTR_W:0];

    function automatic logic [7:0] luma(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        logic [15:0] sum;
        sum = 16'd77 * {8'd0, r} + 16'd150 * {8'd0, g} + 16'd29 * {8'd0, b};
        return sum[15:8];
    endfunction

    function automatic logic [7:0] average(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        logic [9:0]  sum;
        logic [15:0] prod;
        sum  = {2'd0, r} + {2'd0, g} + {2'd0, b};
        prod = 16'd85 * {6'd0, sum};
        return prod[15:8];
    endfunction

    function automatic logic [31:0] shade(input logic [31:0] px, input logic [1:0] m);
        logic [7:0]  y;
        logic [31:0] res;
        res = px;
        y   = 8'd0;
        case (m)
            2'd1: begin
                y   = luma(px[7:0], px[15:8], px[23:16]);
                res = {px[31:24], y, y, y};
            end
            2'd2: begin
                y   = average(px[7:0], px[15:8], px[23:16]);
                res = {px[31:24], y, y, y};
            end
            2'd3:    res = {px[31:24], ~px[23:0]};
            default: res = px;
        endcase
        return res;
    endfunction

    logic [LINE_WIDTH-1:0]  data_p_q [PIPE_STAGES];
    logic [LINE_WIDTH-1:0]  data_p_d [PIPE_STAGES];
    logic [1:0]             mode_p_q [PIPE_STAGES];
    logic [1:0]             mode_p_d [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] last_p_q, last_p_d;
    logic [PIPE_STAGES-1:0] vld_p_q, vld_p_d;

    logic [LINE_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  last_mem_q;
    logic [PTR_W:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]         credits_q, credits_d;
    logic [31:0]            lines_in_q, lines_in_d, lines_out_q, lines_out_d;
    logic                   done_q, done_d;

    logic                   accept, pop, fifo_wr, fifo_empty, fifo_full;
    logic [LINE_WIDTH-1:0]  fifo_wdata;

    always_comb begin
        fifo_empty  = (wr_ptr_q == rd_ptr_q);
        fifo_full   = ((wr_ptr_q - rd_ptr_q) == DEPTH);
        ready_in    = (credits_q < DEPTH);
        valid_out   = !fifo_empty;
        accept      = valid_in && ready_in;
        pop         = valid_out && ready_out;
        fifo_wr     = vld_p_q[LAST_S];
        data_out    = fifo_empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
        last_out    = !fifo_empty && last_mem_q[rd_ptr_q[PTR_W-1:0]];
        idle        = (credits_q == '0);
        lines_in    = lines_in_q;
        lines_out   = lines_out_q;
        done        = done_q;
        wr_ptr_d    = wr_ptr_q + {{PTR_W{1'b0}}, fifo_wr};
        rd_ptr_d    = rd_ptr_q + {{PTR_W{1'b0}}, pop};
        // Credits cover pipeline plus FIFO, so the FIFO can never be overrun.
        credits_d   = credits_q + {{PTR_W{1'b0}}, accept} - {{PTR_W{1'b0}}, pop};
        lines_in_d  = lines_in_q + {31'd0, accept};
        lines_out_d = lines_out_q + {31'd0, pop};
        done_d      = pop && last_out;
    end

    always_comb begin
        vld_p_d[0]  = accept;
        last_p_d[0] = last_in;
        data_p_d[0] = data_in;
        mode_p_d[0] = mode;
        for (int i = 1; i < PIPE_STAGES; i++) begin
            vld_p_d[i]  = vld_p_q[i-1];
            last_p_d[i] = last_p_q[i-1];
            data_p_d[i] = data_p_q[i-1];
            mode_p_d[i] = mode_p_q[i-1];
        end
    end

    // Pipeline exit: each beat is shaded with the mode it was accepted with.
    always_comb begin
        fifo_wdata = '0;
        for (int k = 0; k < NPIX; k++) begin
            fifo_wdata[32*k +: 32] = shade(data_p_q[LAST_S][32*k +: 32], mode_p_q[LAST_S]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            credits_q   <= '0;
            lines_in_q  <= '0;
            lines_out_q <= '0;
            done_q      <= 1'b0;
        end else begin
            vld_p_q     <= vld_p_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            credits_q   <= credits_d;
            lines_in_q  <= lines_in_d;
            lines_out_q <= lines_out_d;
            done_q      <= done_d;
            assert (!(fifo_wr && fifo_full && !pop));
            assert (!(pop && !accept && credits_q == '0));
        end
    end

    // Data-only storage; validity is owned entirely by the reset control state above.
    always_ff @(posedge clk) begin
        data_p_q <= data_p_d;
        mode_p_q <= mode_p_d;
        last_p_q <= last_p_d;
        if (fifo_wr) begin
            mem_q[wr_ptr_q[PTR_W-1:0]]      <= fifo_wdata;
            last_mem_q[wr_ptr_q[PTR_W-1:0]] <= last_p_q[LAST_S];
        end
    end
endmodule

// File: tb/tb_grayscale_stream.sv
// Bench for grayscale_stream: queue-based reference model checked every cycle,
// plus directed literal expectations for the documented scenarios.
module tb_grayscale_stream;
    localparam int LW = 512;
    localparam int PS = 3;
    localparam int FD = 8;
    localparam int NP = LW / 32;

    typedef struct {
        longint        stamp;
        logic [LW-1:0] d;
        logic          l;
    } beat_t;

    logic          clk = 1'b1;
    logic          reset_n = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [LW-1:0] data_in = '0;
    logic          last_in = 1'b0, valid_in = 1'b0, ready_out = 1'b0;
    logic          ready_in, last_out, valid_out, idle, done;
    logic [LW-1:0] data_out;
    logic [31:0]   lines_in, lines_out;

    int            tests = 0;
    int            fails = 0;
    beat_t         q[$];
    longint        ecount = 0;
    int            m_cred = 0;
    logic [31:0]   m_li = '0, m_lo = '0;
    logic          m_done = 1'b0;
    logic          acc_w = 1'b0, pop_w = 1'b0, force_li = 1'b0;
    int            done_seen = 0;
    logic [LW-1:0] got [4];

    always #5 clk = ~clk;

    grayscale_stream #(.LINE_WIDTH(LW), .PIPE_STAGES(PS), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset_n(reset_n), .mode(mode), .data_in(data_in), .last_in(last_in),
        .valid_in(valid_in), .ready_in(ready_in), .data_out(data_out), .last_out(last_out),
        .valid_out(valid_out), .ready_out(ready_out), .lines_in(lines_in),
        .lines_out(lines_out), .idle(idle), .done(done)
    );

    function automatic logic [LW-1:0] rep(input logic [31:0] p);
        logic [LW-1:0] o;
        for (int k = 0; k < NP; k++) o[32*k +: 32] = p;
        return o;
    endfunction

    function automatic logic [LW-1:0] model_line(input logic [LW-1:0] d, input logic [1:0] m);
        logic [LW-1:0] o;
        logic [31:0]   px;
        int            r, g, b, y;
        o = '0;
        for (int k = 0; k < NP; k++) begin
            px = d[32*k +: 32];
            r = int'(px[7:0]);
            g = int'(px[15:8]);
            b = int'(px[23:16]);
            y = 0;
            if (m == 2'd1) y = (77 * r + 150 * g + 29 * b) / 256;
            if (m == 2'd2) y = (85 * (r + g + b)) / 256;
            if (m == 2'd0)      o[32*k +: 32] = px;
            else if (m == 2'd3) o[32*k +: 32] = px ^ 32'h00FF_FFFF;
            else                o[32*k +: 32] = {px[31:24], y[7:0], y[7:0], y[7:0]};
        end
        return o;
    endfunction

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model step at the falling edge: compare, then predict the coming rising edge.
    task automatic mon();
        logic          ev, el;
        logic [LW-1:0] ed;
        acc_w = 1'b0;
        pop_w = 1'b0;
        if (!reset_n) begin
            q.delete();
            m_cred = 0;
            m_li   = '0;
            m_lo   = '0;
            m_done = 1'b0;
        end else begin
            if (force_li) m_li = 32'hFFFF_FFFF;
            ev = (q.size() > 0) && (q[0].stamp + PS <= ecount);
            ed = ev ? q[0].d : '0;
            el = ev && q[0].l;
            check32("valid_out", 32'(valid_out), 32'(ev));
            if (ev) begin
                check("data_out", data_out, ed);
                check32("last_out", 32'(last_out), 32'(el));
            end
            check32("ready_in", 32'(ready_in), 32'(m_cred < FD));
            check32("idle", 32'(idle), 32'(m_cred == 0));
            check32("lines_in", lines_in, m_li);
            check32("lines_out", lines_out, m_lo);
            check32("done", 32'(done), 32'(m_done));
            if (done) done_seen++;
            pop_w  = ev && ready_out;
            acc_w  = valid_in && (m_cred < FD);
            m_done = pop_w && el;
            if (pop_w) begin
                void'(q.pop_front());
                m_lo++;
            end
            if (acc_w) begin
                q.push_back('{ecount + 1, model_line(data_in, mode), last_in});
                m_li++;
            end
            m_cred = m_cred + int'(acc_w) - int'(pop_w);
        end
        ecount++;
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        valid_in = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        int n, d0;
        logic [31:0] pix [4];
        logic [31:0] expd [4];
        logic [1:0]  md [4];
        pix  = '{32'hFF10_2030, 32'h00FF_FFFF, 32'h8012_3456, 32'h1234_5678};
        md   = '{2'd2, 2'd1, 2'd3, 2'd0};
        expd = '{32'hFF1F_1F1F, 32'h00FF_FFFF, 32'h80ED_CBA9, 32'h1234_5678};

        // Reset state
        tick();
        check32("rst_valid_out", 32'(valid_out), 32'd0);
        check32("rst_ready_in", 32'(ready_in), 32'd1);
        check32("rst_idle", 32'(idle), 32'd1);
        check32("rst_done", 32'(done), 32'd0);
        check32("rst_last_out", 32'(last_out), 32'd0);
        check32("rst_lines_in", lines_in, 32'd0);
        check("rst_data_out", data_out, '0);
        reset_n = 1'b1;

        // Single luma beat and its latency
        ready_out = 1'b1;
        mode      = 2'd1;
        data_in   = rep(32'hFF10_2030);
        valid_in  = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        check32("lat_t1", 32'(valid_out), 32'd0);
        tick();
        check32("lat_t2", 32'(valid_out), 32'd0);
        tick();
        check32("lat_t3", 32'(valid_out), 32'd1);
        check("luma_ff102030", data_out, rep(32'hFF23_2323));
        tick();

        // Mixed modes back to back
        for (int i = 0; i < 4; i++) begin
            mode     = md[i];
            data_in  = rep(pix[i]);
            valid_in = 1'b1;
            tick();
        end
        valid_in = 1'b0;
        for (int i = 0; i < 4; i++) got[i] = '0;
        n = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            if (valid_out) begin
                got[n] = data_out;
                n++;
            end
            tick();
        end
        for (int i = 0; i < 4; i++) check($sformatf("mode_beat%0d", i), got[i], rep(expd[i]));

        // Back-pressure: FIFO plus pipeline hold exactly FIFO_DEPTH beats
        do_reset();
        ready_out = 1'b0;
        mode      = 2'd0;
        for (int i = 0; i < 12; i++) begin
            data_in  = rep(32'hA000_0000 + 32'(i));
            valid_in = 1'b1;
            tick();
        end
        valid_in = 1'b0;
        check32("bp_accepted", lines_in, 32'd8);
        check32("bp_ready_in", 32'(ready_in), 32'd0);
        ready_out = 1'b1;
        tick();
        check32("bp_ready_after_pop", 32'(ready_in), 32'd1);
        for (int i = 0; i < 12; i++) tick();
        check32("bp_lines_out", lines_out, 32'd8);

        // 100 beats, random handshakes, cycling modes, last on beat 99
        do_reset();
        n  = 0;
        d0 = done_seen;
        for (int c = 0; c < 3000 && n < 100; c++) begin
            valid_in = ($urandom_range(0, 3) != 0);
            mode     = 2'(n % 4);
            last_in  = (n == 99);
            for (int k = 0; k < NP; k++) data_in[32*k +: 32] = $urandom;
            ready_out = ($urandom_range(0, 2) != 0);
            tick();
            if (acc_w) n++;
        end
        valid_in  = 1'b0;
        last_in   = 1'b0;
        ready_out = 1'b1;
        for (int c = 0; c < 60 && !idle; c++) tick();
        tick();
        check32("rand_lines_in", lines_in, 32'd100);
        check32("rand_lines_out", lines_out, 32'd100);
        check32("rand_idle", 32'(idle), 32'd1);
        check32("rand_done_pulses", 32'(done_seen - d0), 32'd1);

        // Reset with beats in flight
        do_reset();
        ready_out = 1'b0;
        mode      = 2'd0;
        for (int i = 0; i < 5; i++) begin
            data_in  = rep(32'hC0DE_0000 + 32'(i));
            valid_in = 1'b1;
            tick();
        end
        valid_in = 1'b0;
        check32("pre_rst_valid", 32'(valid_out), 32'd1);
        reset_n = 1'b0;
        #1;
        check32("midrst_valid_out", 32'(valid_out), 32'd0);
        check32("midrst_lines_in", lines_in, 32'd0);
        check32("midrst_lines_out", lines_out, 32'd0);
        check32("midrst_idle", 32'(idle), 32'd1);
        tick();
        reset_n   = 1'b1;
        ready_out = 1'b1;
        data_in   = rep(32'h5A5A_0001);
        valid_in  = 1'b1;
        tick();
        valid_in = 1'b0;
        for (int c = 0; c < 10 && !valid_out; c++) tick();
        check32("post_rst_valid", 32'(valid_out), 32'd1);
        check("post_rst_first", data_out, rep(32'h5A5A_0001));
        tick();

        // Counter wrap
        force dut.lines_in_q = 32'hFFFF_FFFF;
        force_li = 1'b1;
        tick();
        release dut.lines_in_q;
        force_li = 1'b0;
        check32("wrap_before", lines_in, 32'hFFFF_FFFF);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        check32("wrap_after", lines_in, 32'd0);
        for (int i = 0; i < 8; i++) tick();

        // Full FIFO with continuous accept and pop
        do_reset();
        ready_out = 1'b0;
        valid_in  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_in = rep(32'hBEEF_0000 + 32'(i));
            tick();
        end
        ready_out = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data_in = rep(32'hF00D_0000 + 32'(i));
            tick();
        end
        check32("full_ready_in", 32'(ready_in), 32'd1);
        check32("full_in_flight", lines_in - lines_out, 32'd7);
        valid_in = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check32("full_idle", 32'(idle), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
